// File: rtl/radix2_divider_pkg.sv
// Shared constants and state encoding for the radix-2 restoring divider.
package radix2_divider_pkg;

   localparam int DIV_W     = 32;
   localparam int DIV_CNT_W = 6;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/radix2_divider_if.sv
// EXE <-> divider handshake: EXE drives the request, the divider answers.
interface radix2_divider_if #(parameter int WIDTH = 32);

   logic             div_begin;
   logic             div_signed;
   logic             div_accept;
   logic [WIDTH-1:0] div_op1;
   logic [WIDTH-1:0] div_op2;
   logic [WIDTH-1:0] div_result;
   logic [WIDTH-1:0] div_remainder;
   logic             div_end;

   modport master (
      output div_begin, div_signed, div_accept, div_op1, div_op2,
      input  div_result, div_remainder, div_end
   );

   modport slave (
      input  div_begin, div_signed, div_accept, div_op1, div_op2,
      output div_result, div_remainder, div_end
   );

endinterface

// File: rtl/radix2_divider_div_step.sv
// One restoring-division iteration: shift {rem, dividend} left, trial
// subtract the divisor, keep the difference when it does not go negative.
module div_step
   import radix2_divider_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic [W-1:0] rem_in,
   input  logic [W-1:0] dvd_in,
   input  logic [W-1:0] dvs_in,
   output logic [W-1:0] rem_out,
   output logic [W-1:0] dvd_out,
   output logic         qbit
);

   logic [W:0] shifted;
   logic [W:0] trial;

   // Because rem < divisor on entry, the trial result always fits in W+1
   // bits, so its top bit is a reliable sign.
   always_comb begin
      shifted = {rem_in, dvd_in[W-1]};
      trial   = shifted - {1'b0, dvs_in};
      qbit    = ~trial[W];
      rem_out = qbit ? trial[W-1:0] : shifted[W-1:0];
      dvd_out = {dvd_in[W-2:0], qbit};
   end

endmodule

// File: rtl/radix2_divider.sv
// Multi-cycle 32-bit DIV/DIVU responder for the EXE div_begin/div_end
// handshake. Magnitudes are divided unsigned, one quotient bit per clock,
// and signs are restored when the final step is registered.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   DIV_IDLE | waiting for div_begin; outputs hold the last results
//   DIV_RUN  | one restoring step per clock, 32 steps total
//   DIV_DONE | div_end high, results stable until accept or flush
module radix2_divider
   import radix2_divider_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic              clk,
   input  logic              reset,
   radix2_divider_if.slave   bus
);

   localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(WIDTH - 1);

   div_state_t           state_q;
   div_state_t           state_d;
   logic [DIV_CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0]     dvd_q;
   logic [WIDTH-1:0]     dvs_q;
   logic [WIDTH-1:0]     rem_q;
   logic                 q_neg_q;
   logic                 r_neg_q;
   logic [WIDTH-1:0]     result_q;
   logic [WIDTH-1:0]     remainder_q;

   logic                 load_en;
   logic                 step_en;
   logic                 finish_en;
   logic                 div_end_c;

   logic [WIDTH-1:0]     op1_mag;
   logic [WIDTH-1:0]     op2_mag;
   logic                 op1_neg;
   logic                 op2_neg;
   logic                 op2_zero;

   logic [WIDTH-1:0]     step_rem;
   logic [WIDTH-1:0]     step_dvd;
   logic                 step_qbit;

   div_step #(.W(WIDTH)) u_step (
      .rem_in  (rem_q),
      .dvd_in  (dvd_q),
      .dvs_in  (dvs_q),
      .rem_out (step_rem),
      .dvd_out (step_dvd),
      .qbit    (step_qbit)
   );

   // Operand magnitudes; the most negative value maps onto itself, which
   // is still the correct unsigned magnitude.
   always_comb begin
      op1_neg  = bus.div_signed & bus.div_op1[WIDTH-1];
      op2_neg  = bus.div_signed & bus.div_op2[WIDTH-1];
      op2_zero = (bus.div_op2 == '0);
      op1_mag  = op1_neg ? (~bus.div_op1 + 1'b1) : bus.div_op1;
      op2_mag  = op2_neg ? (~bus.div_op2 + 1'b1) : bus.div_op2;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= DIV_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; a dropped div_begin is a pipeline flush.
   always_comb begin
      state_d = state_q;
      case (state_q)
         DIV_IDLE: if (bus.div_begin) state_d = DIV_RUN;
         DIV_RUN: begin
            if (!bus.div_begin)           state_d = DIV_IDLE;
            else if (cnt_q == LAST_CNT)   state_d = DIV_DONE;
         end
         DIV_DONE: if (bus.div_accept || !bus.div_begin) state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
   end

   // Output/control decode for the current state.
   always_comb begin
      load_en   = 1'b0;
      step_en   = 1'b0;
      finish_en = 1'b0;
      div_end_c = 1'b0;
      case (state_q)
         DIV_IDLE: load_en = bus.div_begin;
         DIV_RUN: begin
            step_en   = bus.div_begin;
            finish_en = bus.div_begin && (cnt_q == LAST_CNT);
         end
         DIV_DONE: div_end_c = 1'b1;
         default: ;
      endcase
   end

   // Working registers: operand capture at start, one step per RUN clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else if (load_en) begin
         cnt_q   <= '0;
         dvd_q   <= op1_mag;
         dvs_q   <= op2_mag;
         rem_q   <= '0;
         // Divide by zero keeps the all-ones quotient unsigned; the
         // remainder negation still turns |op1| back into op1.
         q_neg_q <= (op1_neg ^ op2_neg) & ~op2_zero;
         r_neg_q <= op1_neg;
      end else if (step_en) begin
         cnt_q   <= cnt_q + 1'b1;
         dvd_q   <= step_dvd;
         rem_q   <= step_rem;
      end
   end

   // Signed results captured from the final step as DONE is entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q    <= '0;
         remainder_q <= '0;
      end else if (finish_en) begin
         result_q    <= q_neg_q ? (~step_dvd + 1'b1) : step_dvd;
         remainder_q <= r_neg_q ? (~step_rem + 1'b1) : step_rem;
      end
   end

   assign bus.div_end       = div_end_c;
   assign bus.div_result    = result_q;
   assign bus.div_remainder = remainder_q;

endmodule
